// File: rtl/arith_pkg.sv
// Shared arithmetic constants and types for the sequential divider.
package arith_pkg;
   localparam int N_DVD     = 16;
   localparam int N_DVS     = 8;
   localparam int DIV_ITERS = 16;

   localparam logic [N_DVD-1:0] DBZ_QUOT = 16'hFFFF;
   localparam logic [N_DVS-1:0] DBZ_REM  = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_t;
endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake between upstream logic and the divider.
interface seq_divider_if;
   import arith_pkg::*;

   logic             start;
   logic [N_DVD-1:0] dividend;
   logic [N_DVS-1:0] divisor;
   logic             busy;
   logic             done;
   logic [N_DVD-1:0] quotient;
   logic [N_DVS-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/CLA.sv
// 16-bit two-level carry-lookahead adder: 4-bit groups, group carries
// resolved directly from cin so no carry depends on another of its vector.
module CLA (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);
   logic [15:0] g;
   logic [15:0] p;
   logic [3:0]  gg;
   logic [3:0]  pg;
   logic [4:0]  cg;

   assign g = x & y;
   assign p = x ^ y;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_grp
         localparam int B = 4 * gi;
         logic c1, c2, c3;

         assign c1 = g[B] | (p[B] & cg[gi]);
         assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
         assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                   | (p[B+2] & p[B+1] & p[B] & cg[gi]);

         assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                       | (p[B+3] & p[B+2] & p[B+1] & g[B]);
         assign pg[gi] = &p[B+3:B];

         assign sum[B+3:B] = p[B+3:B] ^ {c3, c2, c1, cg[gi]};
      end
   endgenerate

   assign cg[0] = cin;
   assign cg[1] = gg[0] | (pg[0] & cin);
   assign cg[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
   assign cg[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                | (pg[2] & pg[1] & pg[0] & cin);
   assign cg[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                | (pg[3] & pg[2] & pg[1] & gg[0]) | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

   assign cout = cg[4];
endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; the trial subtraction
// runs on the shared 16-bit CLA.
module seq_divider
   import arith_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   seq_divider_if.slave  bus
);
   div_state_t       state_reg;
   logic [N_DVD-1:0] dq_reg;
   logic [N_DVS-1:0] dvs_reg;
   logic [N_DVS:0]   pr_reg;
   logic [4:0]       cnt_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [N_DVD-1:0] quot_reg;
   logic [N_DVS-1:0] rem_reg;
   logic             dbz_reg;

   logic [N_DVS:0]   trial;
   logic [15:0]      cla_sum;
   logic             cla_cout;
   logic             no_borrow;
   logic [N_DVS:0]   pr_next;
   logic [N_DVD-1:0] dq_next;
   logic             accept;
   logic             unused_bits;

   assign trial = {pr_reg[N_DVS-1:0], dq_reg[N_DVD-1]};

   CLA u_cla (
      .x    ({{(15-N_DVS){1'b0}}, trial}),
      .y    (~{{(16-N_DVS){1'b0}}, dvs_reg}),
      .cin  (1'b1),
      .sum  (cla_sum),
      .cout (cla_cout)
   );

   // sum bit above the trial width is 1 ^ carry-in-to-that-bit, so its
   // inverse is the no-borrow flag of the 9-bit subtraction.
   assign no_borrow = ~cla_sum[N_DVS+1];
   assign pr_next   = no_borrow ? cla_sum[N_DVS:0] : trial;
   assign dq_next   = {dq_reg[N_DVD-2:0], no_borrow};
   assign accept    = bus.start && !busy_reg;

   assign unused_bits = ^{cla_sum[15:N_DVS+2], cla_cout, pr_reg[N_DVS]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         dq_reg    <= '0;
         dvs_reg   <= '0;
         pr_reg    <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         quot_reg  <= '0;
         rem_reg   <= '0;
         dbz_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (accept) begin
                  dq_reg    <= bus.dividend;
                  dvs_reg   <= bus.divisor;
                  pr_reg    <= '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= CALC;
               end else begin
                  state_reg <= IDLE;
               end
            end
            CALC: begin
               // A zero divisor finishes on the first CALC edge.
               if (dvs_reg == '0) begin
                  quot_reg  <= DBZ_QUOT;
                  rem_reg   <= DBZ_REM;
                  dbz_reg   <= 1'b1;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= DONE;
               end else begin
                  pr_reg  <= pr_next;
                  dq_reg  <= dq_next;
                  cnt_reg <= cnt_reg + 5'd1;
                  if (cnt_reg == 5'(DIV_ITERS - 1)) begin
                     quot_reg  <= dq_next;
                     rem_reg   <= pr_next[N_DVS-1:0];
                     dbz_reg   <= 1'b0;
                     done_reg  <= 1'b1;
                     busy_reg  <= 1'b0;
                     state_reg <= DONE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.quotient    = quot_reg;
   assign bus.remainder   = rem_reg;
   assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench: stimulus pushes model results, a monitor pops on done.
module tb_seq_divider;
   import arith_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_divider_if bus ();

   seq_divider dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int unsigned dvd;
      int unsigned dvs;
      int unsigned q;
      int unsigned r;
      bit          dbz;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input longint act, input longint req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
   endtask

   function automatic exp_t model(input int unsigned dvd, input int unsigned dvs);
      exp_t e;
      e.dvd = dvd;
      e.dvs = dvs;
      e.acc = 0;
      if (dvs == 0) begin
         e.q = 32'hFFFF; e.r = 0; e.dbz = 1'b1; e.lat = 1;
      end else begin
         e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0; e.lat = 16;
      end
      return e;
   endfunction

   // Waits for an idle divider, presents the operands for one accepting edge.
   task automatic issue(input int unsigned dvd, input int unsigned dvs);
      int   waited = 0;
      exp_t e;
      @(negedge clk);
      while (bus.busy && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (bus.busy) begin
         check("issue_wait", !bus.busy, bus.busy, 0);
         return;
      end
      bus.start    = 1'b1;
      bus.dividend = dvd[15:0];
      bus.divisor  = dvs[7:0];
      @(posedge clk);
      #1;
      e = model(dvd, dvs);
      e.acc = cyc;
      sb.push_back(e);
      bus.start = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (bus.done) begin
         check("done_expected", sb.size() != 0, sb.size(), 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("op %0d/%0d -> q=%0d r=%0d dbz=%0d", e.dvd, e.dvs,
                     bus.quotient, bus.remainder, bus.div_by_zero);
            check("quotient", bus.quotient == e.q[15:0], bus.quotient, e.q);
            check("remainder", bus.remainder == e.r[7:0], bus.remainder, e.r);
            check("div_by_zero", bus.div_by_zero == e.dbz, bus.div_by_zero, e.dbz);
            check("latency", (cyc - e.acc) == e.lat, cyc - e.acc, e.lat);
            check("busy_at_done", bus.busy == 1'b0, bus.busy, 0);
            if (!e.dbz) begin
               check("invariant",
                     (int'(bus.quotient) * int'(e.dvs) + int'(bus.remainder)) == int'(e.dvd),
                     int'(bus.quotient) * int'(e.dvs) + int'(bus.remainder), e.dvd);
               check("rem_lt_dvs", int'(bus.remainder) < int'(e.dvs), bus.remainder, e.dvs);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int waited;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Reset state
      @(negedge clk);
      #1;
      check("rst_busy", bus.busy == 1'b0, bus.busy, 0);
      check("rst_done", bus.done == 1'b0, bus.done, 0);
      check("rst_quot", bus.quotient == '0, bus.quotient, 0);
      check("rst_rem", bus.remainder == '0, bus.remainder, 0);
      check("rst_dbz", bus.div_by_zero == 1'b0, bus.div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1000/7 with busy held for the whole computation
      issue(1000, 7);
      ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (!(bus.busy && !bus.done)) ok = 1'b0;
      end
      check("busy_window", ok, ok, 1);

      issue(16'hFFFF, 1);
      issue(5, 200);
      issue(16'hFE01, 8'hFF);

      // Divide by zero then a normal result clears the flag
      issue(1234, 0);
      issue(100, 10);

      // Start while busy is ignored
      issue(1000, 7);
      repeat (5) @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 8'd3;
      @(negedge clk);
      bus.start = 1'b0;

      // Start held high through the DONE cycle: back-to-back acceptance
      issue(1000, 7);
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 8'd3;
      issue(50, 3);

      // Reset in the middle of an operation
      issue(1000, 7);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("abort_busy", bus.busy == 1'b0, bus.busy, 0);
      check("abort_done", bus.done == 1'b0, bus.done, 0);
      check("abort_quot", bus.quotient == '0, bus.quotient, 0);
      check("abort_rem", bus.remainder == '0, bus.remainder, 0);
      check("abort_dbz", bus.div_by_zero == 1'b0, bus.div_by_zero, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(255, 16);

      // Randomised operands, with multiplier round-trips mixed in
      for (int n = 0; n < 2000; n++) begin
         int unsigned a, b;
         if (n % 50 == 0) begin
            a = $urandom_range(1, 255);
            b = $urandom_range(1, 255);
            issue(a * b, a);
         end else begin
            a = $urandom_range(0, 65535);
            b = $urandom_range(1, 255);
            issue(a, b);
         end
      end

      waited = 0;
      while (sb.size() != 0 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("drain", sb.size() == 0, sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
